// File: rtl/wb_regfile_sb.sv
// Write-back register file with per-register in-flight scoreboard and ID stall.
// Optional same-cycle write-back bypass is enabled by defining WB_BYPASS_EN.
module wb_regfile_sb #(
    parameter int DSIZE = 16,
    parameter int ASIZE = 4,
    parameter int CNTW  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic             issue_valid,
    input  logic [ASIZE-1:0] issue_waddr,
    input  logic [ASIZE-1:0] raddrA,
    input  logic [ASIZE-1:0] raddrB,
    output logic [DSIZE-1:0] rdataA,
    output logic [DSIZE-1:0] rdataB,
    output logic             stall,
    output logic             wb_err
);

    localparam int              NREG    = 1 << ASIZE;
    localparam logic [CNTW-1:0] CNT_MAX = '1;
    localparam logic [CNTW-1:0] CNT_ONE = CNTW'(1);

    logic [DSIZE-1:0] r_regs [NREG];
    logic [CNTW-1:0]  r_cnt  [NREG];
    logic             r_wb_err;

    logic             w_fwd_a;
    logic             w_fwd_b;
    logic             w_pend_a;
    logic             w_pend_b;
    logic             w_full;
    logic             w_stall;
    logic [NREG-1:0]  w_inc;
    logic [NREG-1:0]  w_dec;

`ifdef WB_BYPASS_EN
    // Forward only the last pending write so a younger in-flight result is never skipped.
    assign w_fwd_a = wen && (waddr == raddrA) && (raddrA != '0) && (r_cnt[raddrA] == CNT_ONE);
    assign w_fwd_b = wen && (waddr == raddrB) && (raddrB != '0) && (r_cnt[raddrB] == CNT_ONE);
`else
    assign w_fwd_a = 1'b0;
    assign w_fwd_b = 1'b0;
`endif

    assign w_pend_a = (raddrA != '0) && (r_cnt[raddrA] != '0) && !w_fwd_a;
    assign w_pend_b = (raddrB != '0) && (r_cnt[raddrB] != '0) && !w_fwd_b;

    // A write-back retiring the same register frees the slot the issue needs.
    assign w_full   = issue_valid && (issue_waddr != '0) && (r_cnt[issue_waddr] == CNT_MAX)
                      && !(wen && (waddr == issue_waddr));

    assign w_stall  = w_pend_a || w_pend_b || w_full;

    assign rdataA   = (raddrA == '0) ? '0 : (w_fwd_a ? wdata : r_regs[raddrA]);
    assign rdataB   = (raddrB == '0) ? '0 : (w_fwd_b ? wdata : r_regs[raddrB]);
    assign stall    = w_stall;
    assign wb_err   = r_wb_err;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 1; i < NREG; i++) begin
            w_inc[i] = issue_valid && !w_stall && (issue_waddr == ASIZE'(i));
            w_dec[i] = wen && (waddr == ASIZE'(i));
        end
    end

    // NOTE: the array is reset explicitly because reads after reset must return zero,
    // which rules out an un-reset RAM macro for this storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
                r_cnt[i]  <= '0;
            end
            r_wb_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            if (wen && (waddr != '0)) begin
                r_regs[waddr] <= wdata;
            end
            for (int i = 1; i < NREG; i++) begin
                unique case ({w_inc[i], w_dec[i]})
                    2'b10: r_cnt[i] <= r_cnt[i] + CNT_ONE;
                    2'b01: begin
                        if (r_cnt[i] == '0) begin
                            r_wb_err <= 1'b1;
                        end else begin
                            r_cnt[i] <= r_cnt[i] - CNT_ONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
